nios2_key_event_master: RTL and testbench
=========================================

// Module: nios2_key_event_master
// PURPOSE
//  Avalon-MM initiator that services the 4-bit key PIO (edge-capture slave, irq output).
//  - After reset: programs the slave irq_mask once.
//  - On each irq: reads edge_capture, clears it, and pushes {level, edges} into an event FIFO.
//  - Sits between the key PIO slave port and fabric logic that consumes key events without a CPU.
// PARAMETERS
//  MASK_INIT   4'hF  value written to slave irq_mask (address 2) after reset
//  FIFO_DEPTH  4     event FIFO entries; power of two, 2..16
// PORTS
//  clk             in   1   system clock; single clock domain
//  reset_n         in   1   asynchronous, active-low reset
//  irq             in   1   slave interrupt, level, synchronous to clk
//  avm_address     out  2   slave register select
//  avm_chipselect  out  1   slave select
//  avm_write_n     out  1   active-low write strobe
//  avm_writedata   out  32  write data
//  avm_readdata    in   32  slave readdata; registered every cycle from the address, so it is valid
//                           one cycle after the address is driven (no waitrequest)
//  ev_valid        out  1   FIFO head valid
//  ev_ready        in   1   consumer accept; a pop occurs when ev_valid && ev_ready
//  ev_data         out  8   [7:4] key level snapshot, [3:0] captured edges
//  ev_overflow     out  1   sticky; set when an event is dropped on a full FIFO
//  ev_drop_cnt     out  8   dropped-event count, saturates at 8'hFF
// BEHAVIOUR
//  Reset values: avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, ev_valid=0,
//    ev_data=0, ev_overflow=0, ev_drop_cnt=0, FIFO empty, FSM=INIT.
//  FSM; one state per cycle unless noted:
//  - INIT: cs=1, wr_n=0, addr=2, wdata={28'b0,MASK_INIT}. Go to IDLE.
//  - IDLE: cs=0, wr_n=1, addr=0. Go to RD_LVL when irq=1; otherwise stay.
//  - RD_LVL: cs=1, wr_n=1, addr=0. Go to RD_CAP.
//  - RD_CAP: cs=1, wr_n=1, addr=3. Latch lvl=avm_readdata[3:0] (data_in). Go to CLR.
//  - CLR: cs=1, wr_n=0, addr=3, wdata=32'h0000000F. Latch cap=avm_readdata[3:0] (edge_capture).
//    The slave clears all bits on any write to address 3. Go to PUSH.
//  - PUSH: cs=0. Write {lvl,cap} into the FIFO. Go to IDLE.
//  Irq latency: irq rising at cycle T -> clear write in cycle T+3 -> FIFO entry visible at T+5.
//  Edges arriving after the edge_capture sample and before the clear takes effect are lost
//    (1-cycle window). This is accepted, documented behaviour.
//  PUSH with cap==0 (spurious irq): nothing is pushed, no drop is counted.
//  PUSH with cap!=0 and FIFO full:
//    - Entry dropped; ev_overflow<=1; ev_drop_cnt increments (saturating).
//    - Exception: a same-cycle pop frees a slot, so the push succeeds and no drop occurs.
//  irq still high on return to IDLE: a new service cycle starts the next cycle
//    (handles edges that arrived during service).
//  FIFO:
//    - First-word-fall-through; ev_data is the head entry and holds while ev_valid && !ev_ready.
//    - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
//    - Full: pointers differ only in MSB. Empty: pointers equal.
//    - Pop on empty is ignored.
//  ev_overflow and ev_drop_cnt are cleared only by reset.
//  Reset assertion mid-transaction:
//    - All outputs return to reset values asynchronously and the FIFO is flushed.
//    - After release the FSM re-enters INIT, so irq_mask is reprogrammed.
//  Bus outputs are registered; the FSM never drives two transactions in one cycle.
// TESTING
//  1. Release reset -> first cycle shows cs=1, wr_n=0, addr=2, wdata=0xF; then idle with cs=0.
//  2. Slave model: edge_capture=4'b0101, data_in=4'b1010, irq pulsed -> reads addr0 then addr3,
//     clear write addr3 wdata=0xF, ev_valid rises with ev_data=8'hA5 five cycles after irq.
//  3. ev_ready=0; five irq events with cap=1,2,4,8,3 at FIFO_DEPTH=4 -> four entries held,
//     ev_overflow=1, ev_drop_cnt=1; drain -> data order 1,2,4,8, then ev_valid=0.
//  4. Spurious irq with edge_capture=0 -> full bus sequence runs, no FIFO entry, drop_cnt unchanged.
//  5. irq held high across two services (new edge 4'b0010 during CLR) -> second service starts
//     in the cycle after PUSH and queues cap=2.
//  6. Assert reset_n in RD_CAP with two entries queued -> cs=0, ev_valid=0 immediately;
//     after release INIT write repeats and the FIFO is empty.
//  7. Force 300 drops -> ev_drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/nios2_key_event_master.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// nios2_key_event_master : Avalon-MM initiator servicing a 4-bit key PIO and
// queueing {level, edges} key events into a first-word-fall-through FIFO.
// Revision: 1.0
// ----------------------------------------------------------------------------
module nios2_key_event_master #(
  parameter logic [3:0] MASK_INIT  = 4'hF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        irq,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [7:0]  ev_data,
  output logic        ev_overflow,
  output logic [7:0]  ev_drop_cnt
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_LVL, S_RD_CAP, S_CLR, S_PUSH
  } state_e;

  state_e      state_q, state_d;
  logic        boot_q;
  logic        cs_q, cs_d;
  logic        wr_n_q, wr_n_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  lvl_q, cap_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        ovf_q;
  logic [7:0]  drop_q;
  logic        w_empty, w_full, w_pop, w_has_ev, w_push, w_drop;
  logic        unused_rdata;

  assign unused_rdata = ^avm_readdata[31:4];

  // Bus registers are loaded from the next state, so the bus always shows the
  // transaction of the state currently held in state_q.
  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = 2'd0;
    wdata_d = 32'h0;
    case (state_q)
      S_INIT:   if (!boot_q) state_d = S_IDLE;
      S_IDLE:   if (irq) state_d = S_RD_LVL;
      S_RD_LVL: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_CLR;
      S_CLR:    state_d = S_PUSH;
      S_PUSH:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    case (state_d)
      S_INIT: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = 2'd2;
        wdata_d = {28'h0, MASK_INIT};
      end
      S_RD_LVL: cs_d = 1'b1;
      S_RD_CAP: begin
        cs_d   = 1'b1;
        addr_d = 2'd3;
      end
      S_CLR: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = 2'd3;
        wdata_d = 32'h0000_000F;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      boot_q  <= 1'b1;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      addr_q  <= 2'd0;
      wdata_q <= 32'h0;
      lvl_q   <= 4'h0;
      cap_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
      cs_q    <= cs_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == S_RD_CAP) lvl_q <= avm_readdata[3:0];
      if (state_q == S_CLR)    cap_q <= avm_readdata[3:0];
    end
  end

  assign avm_chipselect = cs_q;
  assign avm_write_n    = wr_n_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;

  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop    = !w_empty && ev_ready;
  assign w_has_ev = (state_q == S_PUSH) && (cap_q != 4'h0);
  // A pop in the same cycle frees the slot the push needs.
  assign w_push   = w_has_ev && (!w_full || w_pop);
  assign w_drop   = w_has_ev && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= {lvl_q, cap_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'h00;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (w_drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign ev_valid    = !w_empty;
  assign ev_data     = w_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign ev_overflow = ovf_q;
  assign ev_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_nios2_key_event_master.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nios2_key_event_master : bench with a key PIO slave model, directed
// sequences, a vector table and a randomized queue-based scoreboard.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_nios2_key_event_master;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [7:0]  ev_data;
  logic        ev_overflow;
  logic [7:0]  ev_drop_cnt;

  int checks = 0;
  int errors = 0;

  nios2_key_event_master #(.MASK_INIT(4'hF), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .ev_overflow(ev_overflow), .ev_drop_cnt(ev_drop_cnt)
  );

  always #5 clk = ~clk;

  // Key PIO slave: data_in(0), irq_mask(2), edge_capture(3).
  logic [3:0]  s_mask = 4'h0, s_ec = 4'h0, s_keys = 4'h0, inj = 4'h0;
  logic        force_irq = 1'b0;
  logic [31:0] s_rd = 32'h0;
  assign irq          = (|(s_ec & s_mask)) | force_irq;
  assign avm_readdata = s_rd;

  always @(posedge clk) begin
    case (avm_address)
      2'd0:    s_rd <= {28'h0, s_keys};
      2'd2:    s_rd <= {28'h0, s_mask};
      2'd3:    s_rd <= {28'h0, s_ec};
      default: s_rd <= 32'h0;
    endcase
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2) s_mask <= avm_writedata[3:0];
    s_ec <= ((avm_chipselect && !avm_write_n && avm_address == 2'd3) ? 4'h0 : s_ec) | inj;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string nm, input logic cs, input logic wr_n, input logic [1:0] a);
    chk(nm, {28'h0, avm_chipselect, avm_write_n, avm_address}, {28'h0, cs, wr_n, a});
  endtask

  // Called in cycle T (irq high); walks the four bus cycles of one service.
  task automatic bus_seq(input string tag);
    chk_bus({tag, "_idle"}, 1'b0, 1'b1, 2'd0);
    tick(); force_irq = 1'b0;
    chk_bus({tag, "_rdlvl"}, 1'b1, 1'b1, 2'd0);
    tick();
    chk_bus({tag, "_rdcap"}, 1'b1, 1'b1, 2'd3);
    tick();
    chk_bus({tag, "_clr"}, 1'b1, 1'b0, 2'd3);
    chk({tag, "_clr_wdata"}, avm_writedata, 32'hF);
    tick();
    chk_bus({tag, "_push"}, 1'b0, 1'b1, 2'd0);
  endtask

  task automatic fire(input logic [3:0] edges, input logic [3:0] keys);
    s_keys = keys;
    inj = edges;
    tick();
    inj = 4'h0;
    repeat (7) tick();
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk({nm, "_valid"}, {31'h0, ev_valid}, 32'h1);
    chk({nm, "_data"}, {24'h0, ev_data}, {24'h0, exp});
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  // Reference model: a plain bounded queue with sticky overflow and saturating drops.
  logic [7:0] mq[$];
  int         m_drops = 0;
  logic       m_ovf = 1'b0;

  task automatic mstep(input logic push_en, input logic [7:0] pv);
    @(posedge clk);
    if (ev_ready && mq.size() > 0) void'(mq.pop_front());
    if (push_en && pv[3:0] != 4'h0) begin
      if (mq.size() < DEPTH) mq.push_back(pv);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    #1;
    chk("rnd_valid", {31'h0, ev_valid}, {31'h0, (mq.size() != 0)});
    if (mq.size() != 0) chk("rnd_data", {24'h0, ev_data}, {24'h0, mq[0]});
    chk("rnd_ovf", {31'h0, ev_overflow}, {31'h0, m_ovf});
    chk("rnd_drops", {24'h0, ev_drop_cnt}, 32'(m_drops));
    ev_ready = ($urandom_range(0, 3) == 0);
  endtask

  typedef struct {
    logic [3:0] edges;
    logic [3:0] keys;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[5];
  logic [3:0] caps[5];

  initial begin
    tbl[0] = '{edges: 4'h1, keys: 4'h0, exp: 8'h01};
    tbl[1] = '{edges: 4'hF, keys: 4'hF, exp: 8'hFF};
    tbl[2] = '{edges: 4'h8, keys: 4'h3, exp: 8'h38};
    tbl[3] = '{edges: 4'h6, keys: 4'h9, exp: 8'h96};
    tbl[4] = '{edges: 4'h2, keys: 4'hC, exp: 8'hC2};
    caps   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};

    // 1: reset values, then the one-shot irq_mask write
    repeat (3) tick();
    reset_n = 1'b1;
    chk_bus("rst_bus", 1'b0, 1'b1, 2'd0);
    chk("rst_wdata", avm_writedata, 32'h0);
    chk("rst_valid", {31'h0, ev_valid}, 32'h0);
    chk("rst_data", {24'h0, ev_data}, 32'h0);
    chk("rst_ovf", {31'h0, ev_overflow}, 32'h0);
    chk("rst_drops", {24'h0, ev_drop_cnt}, 32'h0);
    tick();
    chk_bus("init_bus", 1'b1, 1'b0, 2'd2);
    chk("init_wdata", avm_writedata, 32'hF);
    tick();
    chk_bus("init_idle", 1'b0, 1'b1, 2'd0);
    chk("mask_prog", {28'h0, s_mask}, 32'hF);
    tick();

    // 2: single event, full bus sequence and 5-cycle latency
    s_keys = 4'hA;
    inj = 4'h5;
    tick();
    inj = 4'h0;
    bus_seq("t2");
    chk("t2_valid_t4", {31'h0, ev_valid}, 32'h0);
    tick();
    pop_chk("t2_ev", 8'hA5);
    chk("t2_empty", {31'h0, ev_valid}, 32'h0);

    // table of single events
    for (int i = 0; i < 5; i++) begin
      s_keys = tbl[i].keys;
      inj = tbl[i].edges;
      tick();
      inj = 4'h0;
      repeat (4) tick();
      chk("tbl_pre", {31'h0, ev_valid}, 32'h0);
      tick();
      pop_chk("tbl_ev", tbl[i].exp);
      chk("tbl_empty", {31'h0, ev_valid}, 32'h0);
      tick();
    end

    // 3: overflow on a full FIFO, then drain in order
    for (int i = 0; i < 5; i++) fire(caps[i], 4'h0);
    chk("t3_ovf", {31'h0, ev_overflow}, 32'h1);
    chk("t3_drops", {24'h0, ev_drop_cnt}, 32'h1);
    for (int i = 0; i < DEPTH; i++) pop_chk("t3_drain", {4'h0, caps[i]});
    chk("t3_empty", {31'h0, ev_valid}, 32'h0);

    // 4: spurious irq -> bus sequence, nothing queued
    force_irq = 1'b1;
    bus_seq("t4");
    tick();
    chk("t4_valid", {31'h0, ev_valid}, 32'h0);
    chk("t4_drops", {24'h0, ev_drop_cnt}, 32'h1);
    tick();

    // 5: edge arriving during CLR keeps irq high -> back-to-back service
    s_keys = 4'h0;
    inj = 4'h1;
    tick();
    inj = 4'h0;
    repeat (3) tick();
    chk_bus("t5_clr", 1'b1, 1'b0, 2'd3);
    inj = 4'h2;
    tick();
    inj = 4'h0;
    tick();
    chk_bus("t5_idle", 1'b0, 1'b1, 2'd0);
    chk("t5_first", {24'h0, ev_data}, 32'h01);
    tick();
    chk_bus("t5_rdlvl2", 1'b1, 1'b1, 2'd0);
    repeat (6) tick();
    pop_chk("t5_a", 8'h01);
    pop_chk("t5_b", 8'h02);
    chk("t5_empty", {31'h0, ev_valid}, 32'h0);

    // 6: reset in RD_CAP with two entries queued
    fire(4'h3, 4'h0);
    fire(4'h5, 4'h0);
    inj = 4'h4;
    tick();
    inj = 4'h0;
    repeat (2) tick();
    chk_bus("t6_rdcap", 1'b1, 1'b1, 2'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_bus("t6_rst_bus", 1'b0, 1'b1, 2'd0);
    chk("t6_rst_valid", {31'h0, ev_valid}, 32'h0);
    chk("t6_rst_ovf", {31'h0, ev_overflow}, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk_bus("t6_init", 1'b1, 1'b0, 2'd2);
    chk("t6_init_valid", {31'h0, ev_valid}, 32'h0);
    tick();
    chk_bus("t6_idle", 1'b0, 1'b1, 2'd0);
    repeat (5) tick();
    pop_chk("t6_pending", 8'h04);
    chk("t6_empty", {31'h0, ev_valid}, 32'h0);
    tick();

    // 7: drop counter saturation
    for (int i = 0; i < DEPTH + 254; i++) fire(4'h1, 4'h0);
    chk("t7_fe", {24'h0, ev_drop_cnt}, 32'hFE);
    for (int i = 0; i < 46; i++) fire(4'h1, 4'h0);
    chk("t7_ff", {24'h0, ev_drop_cnt}, 32'hFF);
    chk("t7_ovf", {31'h0, ev_overflow}, 32'h1);

    // randomized events with random consumer back-pressure
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    for (int e = 0; e < 80; e++) begin
      logic [3:0] ed;
      logic [3:0] kb;
      ed = 4'($urandom_range(1, 15));
      kb = 4'($urandom_range(0, 15));
      s_keys = kb;
      inj = ed;
      mstep(1'b0, 8'h0);
      inj = 4'h0;
      repeat (4) mstep(1'b0, 8'h0);
      mstep(1'b1, {kb, ed});
      repeat ($urandom_range(0, 3)) mstep(1'b0, 8'h0);
    end
    repeat (40) mstep(1'b0, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
